// File: rtl/csp_cbuf_pkg.sv
// Shared helpers and types for the CSP conditional-buffer family of router blocks.
// Width derivation, route-field placement and a common handshake bundle.
package csp_cbuf_pkg;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // The route field occupies the top ROUTE_W bits of a token.
  function automatic int route_lsb(input int width, input int route_w);
    return width - route_w;
  endfunction

  localparam int HS_DATA_W = 8;

  typedef struct packed {
    logic [HS_DATA_W-1:0] data;
    logic                 valid;
    logic                 ready;
  } hs_t;

endpackage

// File: rtl/cbuf_ram.sv
// Token storage for the conditional buffer: synchronous write, asynchronous read.
module cbuf_ram
  import csp_cbuf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: contents carry no reset; occupancy lives in the control pointers,
  // so stale words are never observed and the array maps onto plain storage.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/csp_cbuf_fifo.sv
// Router input-port buffer: each stored token is sent once on req (route field)
// and once on out (full word); the entry retires only when both have completed.
module csp_cbuf_fifo
  import csp_cbuf_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int ROUTE_W   = 1,
  parameter int REQ_FIRST = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ROUTE_W-1:0]           req_data,
  output logic                         req_valid,
  input  logic                         req_ready,
  output logic [cnt_w(DEPTH)-1:0]      count
);

  localparam int PTR_W     = ptr_w(DEPTH);
  localparam int CNT_W     = cnt_w(DEPTH);
  localparam int ROUTE_LSB = route_lsb(WIDTH, ROUTE_W);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             req_done_q, req_done_d, out_done_q, out_done_d;

  logic             not_empty, push, pop, req_fire, out_fire;
  logic [WIDTH-1:0] head_word;

  cbuf_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (head_word)
  );

  // Offers depend on registered state only, so there is no in->out path.
  always_comb begin
    not_empty = (count_q != '0);
    in_ready  = !reset && (count_q != CNT_W'(DEPTH));
    req_valid = !reset && not_empty && !req_done_q;
    out_valid = !reset && not_empty && !out_done_q && ((REQ_FIRST == 0) || req_done_q);
    req_fire  = req_valid && req_ready;
    out_fire  = out_valid && out_ready;
    push      = in_valid && in_ready;
    pop       = not_empty && (req_done_q || req_fire) && (out_done_q || out_fire);
    out_data  = out_valid ? head_word : '0;
    req_data  = req_valid ? head_word[ROUTE_LSB +: ROUTE_W] : '0;
  end

  assign count = count_q;

  // NOTE: every variable gets its hold value first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    req_done_d = req_done_q;
    out_done_d = out_done_q;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);

    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      req_done_d = 1'b0;
      out_done_d = 1'b0;
    end else begin
      if (req_fire) req_done_d = 1'b1;
      if (out_fire) out_done_d = 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (reset) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      req_done_d = 1'b0;
      out_done_d = 1'b0;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    rd_ptr_q   <= rd_ptr_d;
    wr_ptr_q   <= wr_ptr_d;
    count_q    <= count_d;
    req_done_q <= req_done_d;
    out_done_q <= out_done_d;
  end

endmodule

// File: tb/tb_csp_cbuf_fifo.sv
// Self-checking bench for csp_cbuf_fifo: one instance per REQ_FIRST setting,
// compared every cycle against a token-stream model of the buffer.
module tb_csp_cbuf_fifo;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_data   [2];
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [W-1:0] out_data  [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [0:0]   req_data  [2];
  logic         req_valid [2];
  logic         req_ready [2];
  logic [2:0]   count     [2];

  int n_err = 0;
  int n_chk = 0;
  int k;                 // instance under test; index equals its REQ_FIRST
  logic [W-1:0] words[$]; // every token accepted since the last reset
  int rs, os;            // tokens fully sent on req and on out
  logic [W-1:0] t1_words [3] = '{8'h00, 8'h81, 8'hC3};

  always #5 clk = ~clk;

  csp_cbuf_fifo #(.WIDTH(W), .DEPTH(D), .ROUTE_W(1), .REQ_FIRST(1)) dut_rf1 (
    .clk(clk), .reset(reset),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .req_data(req_data[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .count(count[1])
  );

  csp_cbuf_fifo #(.WIDTH(W), .DEPTH(D), .ROUTE_W(1), .REQ_FIRST(0)) dut_rf0 (
    .clk(clk), .reset(reset),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .req_data(req_data[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .count(count[0])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample at the falling edge, compare with the model, then advance the model
  // by the handshakes the specification says must happen this cycle.
  task automatic tick();
    int popped, cnt;
    logic exp_ir, exp_rv, exp_ov;
    logic [W-1:0] head;
    @(negedge clk);
    popped = (rs < os) ? rs : os;
    cnt    = words.size() - popped;
    head   = (cnt > 0) ? words[popped] : '0;
    exp_ir = !reset && (cnt < D);
    exp_rv = !reset && (cnt > 0) && (rs == popped);
    exp_ov = !reset && (cnt > 0) && (os == popped) && (k == 0 || rs > popped);
    check("count",     32'(count[k]),     32'(cnt));
    check("in_ready",  32'(in_ready[k]),  32'(exp_ir));
    check("req_valid", 32'(req_valid[k]), 32'(exp_rv));
    check("out_valid", 32'(out_valid[k]), 32'(exp_ov));
    check("req_data",  32'(req_data[k]),  exp_rv ? 32'(head[W-1]) : 32'd0);
    check("out_data",  32'(out_data[k]),  exp_ov ? 32'(head) : 32'd0);
    if (reset) begin
      words.delete();
      rs = 0;
      os = 0;
    end else begin
      if (in_valid[k] && exp_ir) words.push_back(in_data[k]);
      if (exp_rv && req_ready[k]) rs++;
      if (exp_ov && out_ready[k]) os++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic switch_to(input int inst);
    k = inst;
    words.delete();
    rs = 0;
    os = 0;
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      req_ready[i] = 1'b0;
      out_ready[i] = 1'b0;
    end
    switch_to(1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    // Three tokens, REQ_FIRST=1: out follows req by one cycle.
    req_ready[1] = 1'b1;
    out_ready[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[1] = 1'b1;
      in_data[1]  = t1_words[i];
      tick();
    end
    in_valid[1] = 1'b0;
    repeat (8) tick();
    check("t1_drained", 32'(count[1]), 32'd0);

    // Fill with out stalled; fifth and sixth offers must be refused.
    out_ready[1] = 1'b0;
    in_valid[1]  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data[1] = 8'(8'h90 + 8'(i) * 8'h23);
      tick();
    end
    check("t2_full_count", 32'(count[1]), 32'd4);
    check("t2_full_ready", 32'(in_ready[1]), 32'd0);
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b1;
    repeat (12) tick();
    check("t2_drained", 32'(count[1]), 32'd0);

    // REQ_FIRST=0 streaming: one word per cycle at constant occupancy.
    switch_to(0);
    req_ready[0] = 1'b1;
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_data[0] = 8'($urandom);
      tick();
      if (i > 0) check("t3_count_one", 32'(count[0]), 32'd1);
    end
    in_valid[0] = 1'b0;
    repeat (3) tick();

    // Pointer wrap with random offers and stalls on both configurations.
    for (int inst = 1; inst >= 0; inst--) begin
      switch_to(inst);
      cyc = 0;
      while (words.size() < 3 * D + 1 && cyc < 600) begin
        in_valid[k]  = 1'($urandom_range(0, 1));
        in_data[k]   = 8'($urandom);
        req_ready[k] = 1'($urandom_range(0, 1));
        out_ready[k] = 1'($urandom_range(0, 1));
        tick();
        cyc++;
      end
      check("wrap_budget", 32'(words.size() >= 3 * D + 1), 32'd1);
      in_valid[k]  = 1'b0;
      req_ready[k] = 1'b1;
      out_ready[k] = 1'b1;
      repeat (12) tick();
      check("wrap_drained", 32'(count[k]), 32'd0);
    end

    // Reset with three stored tokens and the head req already sent.
    switch_to(1);
    req_ready[1] = 1'b1;
    out_ready[1] = 1'b0;
    in_valid[1]  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data[1] = 8'(8'hA1 + 8'(i));
      tick();
    end
    in_valid[1] = 1'b0;
    tick();
    check("t5_count_before", 32'(count[1]), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("t5_count_after",  32'(count[1]),     32'd0);
    check("t5_in_ready",     32'(in_ready[1]),  32'd1);
    check("t5_req_valid",    32'(req_valid[1]), 32'd0);
    check("t5_out_valid",    32'(out_valid[1]), 32'd0);
    out_ready[1] = 1'b1;
    in_valid[1]  = 1'b1;
    in_data[1]   = 8'h5A;
    tick();
    in_valid[1] = 1'b0;
    repeat (4) tick();
    check("t5_drained", 32'(count[1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
